// File: rtl/systemizer_mem_host_if.sv
// systemizer_mem_host_if: host load/unload streams, core RAM port and core run handshake.
interface systemizer_mem_host_if #(parameter int W = 8, parameter int AW = 5);
  logic [W-1:0] host_data;
  logic host_valid;
  logic host_ready;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic sys_start;
  logic sys_done;
  logic sys_success;
  logic sys_fail;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0] data_out;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0] data_in;
  modport master (
    output host_data, host_valid, out_ready, sys_done, sys_success, sys_fail,
           rd_en, rd_addr, wr_en, wr_addr, data_in,
    input  host_ready, out_data, out_valid, sys_start, data_out
  );
  modport slave (
    input  host_data, host_valid, out_ready, sys_done, sys_success, sys_fail,
           rd_en, rd_addr, wr_en, wr_addr, data_in,
    output host_ready, out_data, out_valid, sys_start, data_out
  );
endinterface

// File: rtl/systemizer_mem_host.sv
// systemizer_mem_host: matrix RAM for the systemizer core plus host load/start/unload sequencing.
module systemizer_mem_host #(
  parameter int L = 8,
  parameter int K = 16,
  parameter int M = 3,
  parameter int BLOCK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_load,
  output logic busy,
  output logic result_valid,
  output logic result_success,
  output logic result_fail,
  systemizer_mem_host_if.slave bus
);
  localparam int SW = $clog2(M);
  localparam int W = BLOCK * SW;
  localparam int DEPTH = (L * K) / BLOCK;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEP = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, UNLOAD} state_t;
  state_t state;
  logic [AW:0] cnt;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] out_data, data_out, wdata;
  logic [AW-1:0] waddr;
  logic out_valid, we;
  assign bus.host_ready = state == LOAD;
  assign bus.sys_start = state == RUN;
  assign bus.out_data = out_data;
  assign bus.out_valid = out_valid;
  assign bus.data_out = data_out;
  assign busy = state != IDLE;
  // one write port shared by the host load and the core
  always_comb begin
    we = (state == LOAD && bus.host_valid) ||
         (state == WAIT && bus.wr_en && {1'b0, bus.wr_addr} < DEP);
    waddr = state == LOAD ? cnt[AW-1:0] : bus.wr_addr;
    wdata = state == LOAD ? bus.host_data : bus.data_in;
  end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      data_out <= '0;
      result_valid <= 1'b0;
      result_success <= 1'b0;
      result_fail <= 1'b0;
    end else begin
      if (state == WAIT && bus.rd_en)
        data_out <= {1'b0, bus.rd_addr} < DEP ? mem[bus.rd_addr] : '0;
      case (state)
        IDLE: if (cmd_load) begin
          state <= LOAD;
          cnt <= '0;
          result_valid <= 1'b0;
          result_success <= 1'b0;
          result_fail <= 1'b0;
        end
        LOAD: if (bus.host_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= RUN;
        end
        RUN: state <= WAIT;
        WAIT: if (bus.sys_done) begin
          state <= UNLOAD;
          cnt <= '0;
          result_valid <= 1'b1;
          result_success <= bus.sys_success;
          result_fail <= bus.sys_fail;
        end
        // cnt runs one word ahead of out_data: it is the prefetch address
        UNLOAD: if (!out_valid || bus.out_ready) begin
          if (out_valid && cnt == DEP) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end else begin
            out_data <= mem[cnt[AW-1:0]];
            out_valid <= 1'b1;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systemizer_mem_host.sv
// tb_systemizer_mem_host: randomized runs against an array model; a monitor scoreboards core reads and unload words.
module tb_systemizer_mem_host;
  localparam int W = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  logic clk = 0;
  logic rst = 1;
  logic cmd_load = 0;
  logic busy, result_valid, result_success, result_fail;
  systemizer_mem_host_if #(.W(W), .AW(AW)) bus();
  systemizer_mem_host dut (
    .clk(clk), .rst(rst), .cmd_load(cmd_load), .busy(busy),
    .result_valid(result_valid), .result_success(result_success),
    .result_fail(result_fail), .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m [DEPTH];
  logic [W-1:0] rd_q[$];
  logic [W-1:0] out_q[$];
  logic rd_tag = 0;
  logic rd_pend = 0;
  logic stall = 0;
  logic [W-1:0] stall_data = '0;
  int load_cnt = 0;
  int start_cnt = 0;
  int hs_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rd_pend <= bus.rd_en && rd_tag;

  // monitor: scoreboards core reads, load/start framing and the unload stream
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) check("read_unexpected", 1, 0);
      else check("core_read", bus.data_out, rd_q.pop_front());
    end
    if (bus.host_valid && bus.host_ready) load_cnt++;
    if (bus.sys_start) begin
      check("words_before_start", load_cnt, DEPTH);
      start_cnt++;
    end
    if (stall) check("out_stable", bus.out_data, stall_data);
    if (bus.out_valid && bus.out_ready) begin
      if (out_q.size() == 0) check("unload_extra", 1, 0);
      else check("unload_word", bus.out_data, out_q.pop_front());
      hs_cnt++;
    end
    stall = bus.out_valid && !bus.out_ready;
    stall_data = bus.out_data;
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_host_ready"}, bus.host_ready, 0);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_out_data"}, bus.out_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_sys_start"}, bus.sys_start, 0);
    check({name, "_data_out"}, bus.data_out, 0);
    check({name, "_result"}, {result_valid, result_success, result_fail}, 0);
  endtask

  task automatic start_load();
    cmd_load = 1;
    tick();
    cmd_load = 0;
    load_cnt = 0;
    start_cnt = 0;
    check("host_ready_after_cmd", bus.host_ready, 1);
    check("busy_after_cmd", busy, 1);
    check("result_cleared", result_valid, 0);
  endtask

  task automatic load(input bit seq, input bit gaps);
    int i;
    int n;
    bit gapped;
    logic [W-1:0] d;
    i = 0;
    n = 0;
    gapped = 0;
    while (i < DEPTH && n < 2000) begin
      if (gaps && i == 16 && !gapped) begin
        bus.host_valid = 0;
        repeat (10) begin
          cmd_load = 1;
          tick();
        end
        cmd_load = 0;
        gapped = 1;
        check("gap_holds_load", {bus.host_ready, bus.sys_start}, 2'b10);
        check("gap_word_count", load_cnt, 16);
      end
      d = seq ? W'(i) : W'($urandom);
      bus.host_data = d;
      bus.host_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.host_valid && bus.host_ready) begin
        m[i] = d;
        i++;
      end
      tick();
      n++;
    end
    bus.host_valid = 0;
    if (i < DEPTH) check("load_timeout", i, DEPTH);
    tick();
    check("start_pulses", start_cnt, 1);
    check("start_low_in_wait", bus.sys_start, 0);
  endtask

  task automatic op(input bit r, input bit w, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                    input logic [W-1:0] wd);
    bus.rd_en = r;
    rd_tag = r;
    bus.rd_addr = ra;
    bus.wr_en = w;
    bus.wr_addr = wa;
    bus.data_in = wd;
    if (r) rd_q.push_back(m[ra]);
    if (w) m[wa] = wd;
    tick();
  endtask

  task automatic core_ops(input int n);
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    for (int i = 0; i < n; i++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, wa, W'($urandom));
    end
    op(0, 0, '0, '0, '0);
    tick();
    check("reads_drained", rd_q.size(), 0);
    check("single_start", start_cnt, 1);
  endtask

  task automatic finish_run(input bit s, input bit f, input bit toggle);
    int n;
    bus.out_ready = 0;
    bus.sys_done = 1;
    bus.sys_success = s;
    bus.sys_fail = f;
    for (int i = 0; i < DEPTH; i++) out_q.push_back(m[i]);
    hs_cnt = 0;
    tick();
    bus.sys_done = 0;
    bus.sys_success = 0;
    bus.sys_fail = 0;
    check("flags_after_done", {result_valid, result_success, result_fail}, {1'b1, s, f});
    check("out_valid_t1", bus.out_valid, 0);
    tick();
    check("out_valid_t2", bus.out_valid, 1);
    check("first_word", bus.out_data, m[0]);
    n = 0;
    while (hs_cnt < DEPTH && n < 500) begin
      bus.out_ready = toggle ? ~bus.out_ready : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    bus.out_ready = 0;
    check("unload_count", hs_cnt, DEPTH);
    check("queue_empty", out_q.size(), 0);
    check("busy_after_unload", {busy, bus.out_valid}, 0);
    check("flags_held", {result_valid, result_success, result_fail}, {1'b1, s, f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.host_data = '0;
    bus.host_valid = 0;
    bus.out_ready = 0;
    bus.sys_done = 0;
    bus.sys_success = 0;
    bus.sys_fail = 0;
    bus.rd_en = 0;
    bus.rd_addr = '0;
    bus.wr_en = 0;
    bus.wr_addr = '0;
    bus.data_in = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 0;
    tick();
    repeat (6) begin
      bus.rd_en = 1'($urandom_range(0, 1));
      bus.wr_en = 1'($urandom_range(0, 1));
      bus.rd_addr = AW'($urandom);
      bus.wr_addr = AW'($urandom);
      bus.data_in = W'($urandom);
      bus.sys_done = 1;
      bus.sys_success = 1;
      tick();
    end
    bus.rd_en = 0;
    bus.wr_en = 0;
    bus.sys_done = 0;
    bus.sys_success = 0;
    check_idle_outputs("idle_ignore");
    // run 1: counting pattern, directed read and same-address collision
    start_load();
    load(1, 0);
    op(1, 0, 5, 0, 0);
    op(1, 1, 3, 3, 8'hA5);
    op(1, 0, 3, 0, 0);
    core_ops(20);
    finish_run(1, 0, 1);
    bus.sys_done = 1;
    bus.sys_fail = 1;
    tick();
    bus.sys_done = 0;
    bus.sys_fail = 0;
    tick();
    check("done_ignored_idle", {result_valid, result_success, result_fail, busy}, 4'b1100);
    // run 2: random data, stalled load with ignored cmd_load
    start_load();
    load(0, 1);
    core_ops(30);
    finish_run(0, 1, 0);
    // reset in WAIT, then a clean run
    start_load();
    load(0, 0);
    core_ops(5);
    #2;
    rst = 1;
    #1;
    check_idle_outputs("reset_mid_run");
    tick();
    rst = 0;
    tick();
    check_idle_outputs("after_reset");
    start_load();
    load(0, 0);
    core_ops(10);
    finish_run(0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systemizer_mem_host.md
# systemizer_mem_host

Memory responder and host sequencer for the systemizer core. Holds the L×K matrix as a DEPTH-word synchronous RAM and answers the core's `rd_en/rd_addr → data_out` and `wr_en/wr_addr/data_in` requests. It also frames each run for the host: a streamed load of all words, a one-cycle `sys_start` pulse, capture of `done/success/fail`, then a streamed unload of the result matrix.

## Interface
Parameters:
- `L`, default 8: matrix rows.
- `K`, default 16: matrix columns.
- `M`, default 3: field size; symbol width `SW = CLOG2(M)` (2).
- `BLOCK`, default 4: symbols per word. Word width `W = BLOCK*SW` (8).
- Derived: `DEPTH = (L*K)/BLOCK` (32). Address width `AW = CLOG2(DEPTH)` (5).

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_load` in 1: single-cycle request to begin a run. Honoured only in IDLE.
- `host_data` in W: load word.
- `host_valid` in 1: load word valid.
- `host_ready` out 1: load word accepted when `host_valid & host_ready`.
- `out_data` out W: unload word.
- `out_valid` out 1: unload word valid.
- `out_ready` in 1: unload word consumed when `out_valid & out_ready`.
- `busy` out 1: high in every state except IDLE.
- `result_valid` out 1: a result has been captured.
- `result_success` out 1: captured `sys_success`.
- `result_fail` out 1: captured `sys_fail`.
- `sys_start` out 1: start pulse to the core.
- `sys_done` in 1: core finished.
- `sys_success` in 1: core result flag.
- `sys_fail` in 1: core result flag.
- `rd_en` in 1: core read request.
- `rd_addr` in AW: core read address.
- `data_out` out W: read data returned to the core.
- `wr_en` in 1: core write request.
- `wr_addr` in AW: core write address.
- `data_in` in W: core write data.

## Operation
- FSM states: IDLE, LOAD, RUN, WAIT, UNLOAD.
- Reset: state IDLE; counters 0. Every output 0: `host_ready`, `out_valid`, `out_data`, `busy`, `result_*`, `sys_start`, `data_out`. RAM contents are not reset.
- IDLE:
  - `cmd_load` → LOAD, load counter cleared.
  - `cmd_load` also clears `result_valid`, `result_success` and `result_fail`.
- LOAD:
  - `host_ready` = 1.
  - Each accepted word is written to `mem[cnt]`, then `cnt++`.
  - Acceptance of word DEPTH-1 → RUN.
  - `host_valid` low stalls the load indefinitely.
- RUN: `sys_start` = 1 for exactly one cycle → WAIT.
- WAIT (core owns the RAM):
  - `rd_en` → `data_out` = `mem[rd_addr]` on the next cycle. `data_out` holds its value when `rd_en` is low.
  - `wr_en` → `mem[wr_addr]` = `data_in`.
  - Read and write to the same address in one cycle: the read returns the old data.
  - Reads and writes to different addresses in one cycle are both serviced.
  - `sys_done` → capture `sys_success` and `sys_fail` from that same cycle, set `result_valid` = 1, go to UNLOAD.
- UNLOAD:
  - Streams `mem[0]` … `mem[DEPTH-1]` on `out_data` using a valid/ready handshake.
  - `out_data` is stable while `out_valid & !out_ready`.
  - Sustains one word per cycle while `out_ready` is held high; the next address is prefetched on each handshake.
  - Handshake of word DEPTH-1 → IDLE, with `out_valid` low the following cycle.
- Ignored inputs:
  - `rd_en`, `wr_en`, `sys_done` outside WAIT have no effect on RAM, state or flags.
  - `cmd_load` outside IDLE has no effect.
  - `host_valid` outside LOAD has no effect.
- Address width: addresses are exactly AW bits. For non-power-of-two DEPTH, core accesses with address ≥ DEPTH are dropped (writes) or return 0 (reads).
- Reset mid-run: any state returns to IDLE immediately. A pending `sys_start` or `out_valid` drops asynchronously.

## Timing
- Load: one word per cycle maximum; `host_ready` rises the cycle after `cmd_load`.
- Start: `sys_start` is high in cycle t+1 when the last load handshake occurs in cycle t.
- Core read latency: exactly 1 cycle (`rd_en` at t → `data_out` valid at t+1). Back-to-back reads are supported every cycle.
- Core write: takes effect at the end of cycle t. A read issued at t+1 returns the new value.
- Unload start: `sys_done` at t → `out_valid` = 1 with `mem[0]` at t+2.
- Result flags: valid from t+1 and held until the next honoured `cmd_load`.
- `busy`: rises the cycle after `cmd_load`; falls the cycle after the final unload handshake.

## Test plan
- Reset then idle: all outputs 0. `rd_en`/`wr_en`/`sys_done` toggling in IDLE leaves RAM unchanged and `result_valid` = 0.
- Load and round-trip: `cmd_load`, then load words 0x00..0x1F with `host_valid` held. Expect `sys_start` for exactly 1 cycle, one cycle after word 0x1F. In WAIT, `rd_en` at addr 5 → `data_out` = 0x05 on the next cycle.
- Core write plus collision: in WAIT, `wr_en` addr 3 data 0xA5 together with `rd_en` addr 3 → `data_out` = 0x03. Then `rd_en` addr 3 → 0xA5. `sys_done` with `sys_success` = 1 → `result_success` = 1, `result_fail` = 0.
- Unload backpressure: toggle `out_ready` 1/0. Expect 32 words 0x00..0x1F in order, except 0xA5 at index 3. `out_data` stays stable while stalled; `busy` falls after the 32nd handshake.
- Stalled load: gap `host_valid` low for 10 cycles mid-load. The word count still ends at exactly 32 before `sys_start`. A `cmd_load` issued during LOAD is ignored.
- Reset mid-run: assert `rst` in WAIT → all outputs 0 and state IDLE. A subsequent full run completes normally with the `sys_fail` = 1 result captured.
